fcvtsw_pipe: RTL

Pipelined signed-32-bit-integer to IEEE-754 single-precision converter (fcvt.s.w), the inverse of the FPU's float-to-int converter. It sits in the FPU execute path between the integer operand bus and the FP writeback. Rounding is round-to-nearest-even, with a 3-stage pipeline and valid/ready handshakes on both ends.

---
 rtl/fcvtsw_pipe_pkg.sv | 28 ++
 rtl/fcvtsw_pipe_if.sv | 31 +++
 rtl/fcvtsw_pipe_lzc32.sv | 16 +
 rtl/fcvtsw_pipe.sv | 80 ++++++++
 4 files changed

// File: rtl/fcvtsw_pipe_pkg.sv
// fcvtsw_pipe: shared FPU types and constants for the int32 -> single converter.
// Build option: FCVTSW_INEXACT_EN adds the inexact flag.
package fcvtsw_pipe_pkg;

  localparam logic [7:0] BIAS_PLUS_31 = 8'd158;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

  typedef struct packed {
    logic        v;
    logic        s;
    logic        z;
    logic [31:0] a;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic        s;
    logic        z;
    logic [31:0] m;
    logic [7:0]  e;
  } s2_t;

endpackage

// File: rtl/fcvtsw_pipe_if.sv
// fcvtsw_pipe: operand/result handshake bundle.
// Build option: FCVTSW_INEXACT_EN adds the inexact signal.
interface fcvtsw_pipe_if;

  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
`ifdef FCVTSW_INEXACT_EN
  logic        inexact;
`endif

  modport master (
    output x, in_valid, out_ready,
    input  in_ready, y, out_valid
`ifdef FCVTSW_INEXACT_EN
    , input inexact
`endif
  );

  modport slave (
    input  x, in_valid, out_ready,
    output in_ready, y, out_valid
`ifdef FCVTSW_INEXACT_EN
    , output inexact
`endif
  );

endinterface

// File: rtl/fcvtsw_pipe_lzc32.sv
// fcvtsw_pipe: 32-bit leading-zero counter.
// Zero input gives 0; callers handle zero separately.
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  n
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    n = '0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) n = 5'(31 - i);
    end
  end

endmodule

// File: rtl/fcvtsw_pipe.sv
// fcvtsw_pipe: 3-stage int32 -> IEEE single converter, RNE rounding.
// Build option: FCVTSW_INEXACT_EN adds the inexact output.
module fcvtsw_pipe
  import fcvtsw_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fcvtsw_pipe_if.slave io
);

  logic        en;
  s1_t         s1_q;
  s2_t         s2_q;
  logic [4:0]  n;
  logic        up;
  logic [23:0] fr;
  logic [7:0]  e3;
  float_t      y_d;
  float_t      y_q;
  logic        ov_q;

  assign en          = !ov_q || io.out_ready;
  assign io.in_ready = en;
  assign io.out_valid = ov_q;
  assign io.y        = y_q;

  lzc32 u_lzc (
    .a (s1_q.a),
    .n (n)
  );

  // Mantissa carry-out bumps the exponent and clears f.
  always_comb begin
    up  = s2_q.m[7] && ((|s2_q.m[6:0]) || s2_q.m[8]);
    fr  = {1'b0, s2_q.m[30:8]} + {23'd0, up};
    e3  = s2_q.e + {7'd0, fr[23]};
    y_d = '0;
    if (!s2_q.z) begin
      y_d.sign = s2_q.s;
      y_d.exp  = e3;
      y_d.man  = fr[22:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      ov_q <= 1'b0;
      y_q  <= '0;
    end else if (en) begin
      s1_q.v <= io.in_valid;
      s1_q.s <= io.x[31];
      s1_q.z <= (io.x == 32'd0);
      s1_q.a <= io.x[31] ? -io.x : io.x;
      s2_q.v <= s1_q.v;
      s2_q.s <= s1_q.s;
      s2_q.z <= s1_q.z;
      s2_q.m <= s1_q.a << n;
      s2_q.e <= BIAS_PLUS_31 - {3'd0, n};
      ov_q   <= s2_q.v;
      y_q    <= y_d;
    end
  end

`ifdef FCVTSW_INEXACT_EN
  logic inx_q;

  assign io.inexact = inx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inx_q <= 1'b0;
    end else if (en) begin
      inx_q <= |s2_q.m[7:0];
    end
  end
`endif

endmodule
